// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store sequencer between the execute stage and a
//            gnt/rvalid memory port. Define LSU_MISALIGN_CHECK_EN to reject
//            misaligned accesses and illegal funct3 codes.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] load_data,
    output logic             misaligned,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_sdata;
    logic [WIDTH-1:0] r_load_data;
    logic             r_misaligned;

    logic             w_accept;
    logic             w_reject;
    logic             w_byte;
    logic             w_half;
    logic [1:0]       w_lane;
    logic [15:0]      w_low;
    logic [WIDTH-1:0] w_load_ext;

    assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
    logic w_in_byte;
    logic w_in_half;
    logic w_in_word;

    always_comb begin
        w_in_byte = (funct3 == 3'b000) || (!is_store && (funct3 == 3'b100));
        w_in_half = (funct3 == 3'b001) || (!is_store && (funct3 == 3'b101));
        w_in_word = (funct3 == 3'b010);
        w_reject  = !(w_in_byte || w_in_half || w_in_word)
                  || (w_in_half && addr[0])
                  || (w_in_word && (addr[1:0] != 2'b00));
    end
`else
    assign w_reject = 1'b0;
`endif

    // Size decode of the latched access; anything not byte/half is a word.
    always_comb begin
        w_byte = (r_funct3 == 3'b000) || (!r_is_store && (r_funct3 == 3'b100));
        w_half = (r_funct3 == 3'b001) || (!r_is_store && (r_funct3 == 3'b101));
        w_lane = 2'b00;
        if (w_byte) begin
            w_lane = r_addr[1:0];
        end else if (w_half) begin
            w_lane = {r_addr[1], 1'b0};
        end
    end

    always_comb begin
        w_low      = 16'(mem_rdata >> {w_lane, 3'b000});
        w_load_ext = mem_rdata;
        if (w_byte) begin
            w_load_ext = {{24{!r_funct3[2] && w_low[7]}}, w_low[7:0]};
        end else if (w_half) begin
            w_load_ext = {{16{!r_funct3[2] && w_low[15]}}, w_low[15:0]};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_reject ? S_DONE : S_REQ;
            S_REQ:  if (mem_gnt) w_next = r_is_store ? S_DONE : S_WAIT;
            S_WAIT: if (mem_rvalid) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory-side outputs are forced to zero outside the request phase.
    always_comb begin
        mem_req   = (r_state == S_REQ);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = 4'b0000;
        mem_wdata = '0;
        if (r_state == S_REQ) begin
            mem_addr = {r_addr[WIDTH-1:2], 2'b00};
            if (r_is_store) begin
                mem_we = 1'b1;
                if (w_byte) begin
                    mem_wstrb = 4'b0001 << w_lane;
                    mem_wdata = {4{r_sdata[7:0]}};
                end else if (w_half) begin
                    mem_wstrb = 4'b0011 << w_lane;
                    mem_wdata = {2{r_sdata[15:0]}};
                end else begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = r_sdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_sdata      <= '0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_store <= is_store;
                r_funct3   <= funct3;
                r_addr     <= addr;
                r_sdata    <= store_data;
            end
            // Result registers change only on entry to DONE, so they hold between responses.
            if (w_accept && w_reject) begin
                r_load_data  <= '0;
                r_misaligned <= 1'b1;
            end
            if ((r_state == S_REQ) && mem_gnt && r_is_store) begin
                r_load_data  <= '0;
                r_misaligned <= 1'b0;
            end
            if ((r_state == S_WAIT) && mem_rvalid) begin
                r_load_data  <= w_load_ext;
                r_misaligned <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign load_data  = r_load_data;
    assign misaligned = r_misaligned;

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 Ports, one per line (name direction width meaning). The block SHALL have one clock, and reset SHALL be synchronous and active-high:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  high only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width code: LB=000 LH=001 LW=010 LBU=100 LHU=101 SB=000 SH=001 SW=010
- addr  in  WIDTH  effective address, the ALU sum result
- store_data  in  WIDTH  rs2 value
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  WIDTH  word-aligned address {addr[31:2],2'b00}
- mem_wstrb  out  4  byte lane strobes
- mem_wdata  out  WIDTH  lane-replicated store data
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WIDTH  read word
- resp_valid  out  1  access complete, one-cycle pulse
- load_data  out  WIDTH  extended load result
- misaligned  out  1  access rejected, qualified by resp_valid
- busy  out  1  state != IDLE

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT and DONE. Handshake: req_valid && req_ready in IDLE SHALL latch is_store, funct3, addr and store_data.
REQ-004 Transitions SHALL be as follows. IDLE goes to REQ on acceptance. If the access is misaligned or funct3 is illegal, IDLE SHALL go to DONE with misaligned=1 and SHALL NOT assert mem_req.
REQ-005 In REQ, mem_req=1 with mem_we/mem_addr/mem_wstrb/mem_wdata held stable until mem_gnt. On mem_gnt, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-006 WAIT SHALL go to DONE on mem_rvalid, capturing the extracted load_data. mem_rvalid SHALL be ignored in every other state; the memory side guarantees rvalid arrives at least one cycle after gnt.
REQ-007 DONE SHALL assert resp_valid for exactly one cycle, then return to IDLE. A new request SHALL NOT be accepted in DONE.
REQ-008 Latency from the acceptance cycle N, with zero-wait gnt in N+1: a store SHALL assert resp_valid at N+2. A load with rvalid at N+2 SHALL assert resp_valid at N+3. A misaligned access SHALL assert resp_valid at N+1.
REQ-009 Misalignment is defined as a halfword with addr[0]=1, or a word with addr[1:0]!=0. Illegal funct3 is any value other than those listed for loads (000,001,010,100,101) or stores (000,001,010).
REQ-010 Store lanes SHALL be driven as follows:
- SB: wstrb = 0001 << addr[1:0], wdata = {4{sd[7:0]}}
- SH: wstrb = 0011 << {addr[1],0}, wdata = {2{sd[15:0]}}
- SW: wstrb = 1111, wdata = sd
REQ-011 Loads SHALL shift rdata right by 8*addr[1:0] and take the low byte or halfword. LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the word through.
REQ-012 load_data SHALL be 0 for stores and for rejected accesses. Outputs SHALL hold their values until the next resp_valid.
REQ-013 mem_we, mem_wstrb and mem_wdata SHALL be 0 whenever mem_req=0.

Reset
REQ-014 rst SHALL force IDLE on the next clk edge from any state, including REQ and WAIT. It SHALL drop mem_req the same edge and discard any pending response.
REQ-015 Reset values SHALL be: mem_req=0, mem_we=0, mem_wstrb=0, mem_wdata=0, mem_addr=0, resp_valid=0, load_data=0, misaligned=0, busy=0. req_ready SHALL be 1 after reset.

Configuration
REQ-016 Macro LSU_MISALIGN_CHECK_EN: when defined, REQ-004 and REQ-009 rejection SHALL apply.
REQ-017 When the macro is undefined, misaligned SHALL be tied 0 and no access is rejected. Halfword accesses SHALL use addr[1] only, and word accesses SHALL ignore addr[1:0]. Illegal funct3 SHALL be treated as a word access.

Verification
REQ-018 LW addr=0x100, gnt on first REQ cycle, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, resp_valid at N+3, load_data=0xDEADBEEF, misaligned=0.
REQ-019 LB addr=0x103, rdata=0x80FF1234 -> load_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
REQ-020 SB addr=0x201, sd=0x000000AB, gnt delayed 3 cycles -> mem_req held 4 cycles with mem_wstrb=0010 and mem_wdata=0xABABABAB stable; resp_valid one cycle after gnt.
REQ-021 With macro defined: SW addr=0x202 -> no mem_req, resp_valid at N+1 with misaligned=1. With macro undefined: the same access issues mem_req with wstrb=1111 and mem_addr=0x200.
REQ-022 LW accepted, rst asserted in WAIT, rvalid then arrives -> IDLE next edge, no resp_valid, req_ready=1, next LW completes normally.
